// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Holds the FSM state encoding, the requester-id type and the word geometry.
package mem_arb_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN,
    ST_RESP
  } arb_state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  // A beat touches memory for every load/fetch byte, but only for enabled store bytes.
  function automatic logic beat_enabled(input logic we,
                                        input logic [BYTES_PER_WORD-1:0] be,
                                        input logic [1:0] k);
    return !we || be[k];
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker between fetch and data requesters.
// The last-grant register starts at fetch so data wins the first tie after reset.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_fetch,
  input  logic req_data,
  input  logic take,
  output logic gnt_valid,
  output logic gnt_data
);

  req_id_e last_q, last_d;
  req_id_e pick;

  // Choose the requester; on a tie prefer whoever was not granted last.
  always_comb begin
    pick = REQ_FETCH;
    if (req_fetch && req_data) begin
      pick = (last_q == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (req_data) begin
      pick = REQ_DATA;
    end
    last_d = last_q;
    if (take && (req_fetch || req_data)) begin
      last_d = pick;
    end
  end

  assign gnt_valid = req_fetch || req_data;
  assign gnt_data  = (pick == REQ_DATA);

  // Remember the most recent grant only when the arbiter actually takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_FETCH;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port byte-wide memory between an instruction-fetch port
// and a load/store port, one 32-bit word (four byte beats) at a time.
// Optional feature: define MEM_ARB_MISALIGN_CHK_EN to reject accesses whose
// address is not word aligned with an error response and no memory traffic.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_req,
  input  logic [ADDR_WIDTH-1:0]    if_addr,
  output logic                     if_valid,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  output logic                     if_err,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDR_WIDTH-1:0]    d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  input  logic [3:0]               d_be,
  output logic                     d_valid,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     d_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata
);

  localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_WORD - 1);

  arb_state_e               state_q, state_d;
  logic [1:0]               beat_q, beat_d;
  req_id_e                  owner_q, owner_d;
  logic                     we_q, we_d;
  logic [3:0]               be_q, be_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [MEM_ADDR_BITS-1:0] base_q, base_d;
  logic [23:0]              rbuf_q, rbuf_d;
  logic                     mem_en_q, mem_en_d;
  logic                     mem_we_q, mem_we_d;
  logic [MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]               mem_wdata_q, mem_wdata_d;
  logic                     if_valid_q, if_valid_d;
  logic                     d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0]    if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]    d_rdata_q, d_rdata_d;

  logic                     gnt_valid;
  logic                     gnt_data;
  logic [MEM_ADDR_BITS-1:0] sel_addr;
  logic                     sel_we;
  logic [3:0]               sel_be;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic [1:0]               next_beat;
  logic                     unused_addr_bits;

  // Only the low address bits reach the byte memory; upper bits are ignored.
  assign unused_addr_bits = ^{if_addr[ADDR_WIDTH-1:MEM_ADDR_BITS],
                              d_addr[ADDR_WIDTH-1:MEM_ADDR_BITS]};

`ifdef MEM_ARB_MISALIGN_CHK_EN
  logic if_err_q, if_err_d;
  logic d_err_q, d_err_d;
`endif

  mem_arb_rr u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_fetch (if_req),
    .req_data  (d_req),
    .take      (state_q == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_data  (gnt_data)
  );

  // Mux the granted requester's transaction attributes for latching in IDLE.
  always_comb begin
    sel_addr  = gnt_data ? d_addr[MEM_ADDR_BITS-1:0] : if_addr[MEM_ADDR_BITS-1:0];
    sel_we    = gnt_data && d_we;
    sel_be    = gnt_data ? d_be : 4'hF;
    sel_wdata = gnt_data ? d_wdata : '0;
  end

  // Next-state and registered-output logic for the IDLE/XFER/DRAIN/RESP sequence.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    owner_d     = owner_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    base_d      = base_q;
    rbuf_d      = rbuf_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    next_beat   = beat_q + 2'd1;
`ifdef MEM_ARB_MISALIGN_CHK_EN
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_data ? REQ_DATA : REQ_FETCH;
          we_d    = sel_we;
          be_d    = sel_be;
          wdata_d = sel_wdata;
          base_d  = sel_addr;
`ifdef MEM_ARB_MISALIGN_CHK_EN
          if (sel_addr[1:0] != 2'b00) begin
            state_d = ST_RESP;
            if (gnt_data) begin
              d_valid_d = 1'b1;
              d_err_d   = 1'b1;
              d_rdata_d = '0;
            end else begin
              if_valid_d = 1'b1;
              if_err_d   = 1'b1;
              if_rdata_d = '0;
            end
          end else
`endif
          begin
            state_d     = ST_XFER;
            beat_d      = 2'd0;
            mem_en_d    = beat_enabled(sel_we, sel_be, 2'd0);
            mem_we_d    = sel_we && sel_be[0];
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata[7:0];
          end
        end
      end

      ST_XFER: begin
        if (beat_q != 2'd0) begin
          rbuf_d[{beat_q - 2'd1, 3'b000} +: 8] = mem_rdata;
        end
        if (beat_q == LAST_BEAT) begin
          state_d = ST_DRAIN;
        end else begin
          beat_d      = next_beat;
          mem_en_d    = beat_enabled(we_q, be_q, next_beat);
          mem_we_d    = we_q && be_q[next_beat];
          mem_addr_d  = base_q + MEM_ADDR_BITS'(next_beat);
          mem_wdata_d = wdata_q[{next_beat, 3'b000} +: 8];
        end
      end

      ST_DRAIN: begin
        state_d = ST_RESP;
        if (owner_q == REQ_DATA) begin
          d_valid_d = 1'b1;
          if (!we_q) begin
            d_rdata_d = DATA_WIDTH'({mem_rdata, rbuf_q});
          end
        end else begin
          if_valid_d = 1'b1;
          if_rdata_d = DATA_WIDTH'({mem_rdata, rbuf_q});
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= 2'd0;
      owner_q     <= REQ_FETCH;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      wdata_q     <= '0;
      base_q      <= '0;
      rbuf_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      base_q      <= base_d;
      rbuf_q      <= rbuf_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_MISALIGN_CHK_EN
  // Error flags accompany the valid pulse of a rejected misaligned access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;
    end else begin
      if_err_q <= if_err_d;
      d_err_q  <= d_err_d;
    end
  end

  assign if_err = if_err_q;
  assign d_err  = d_err_q;
`else
  assign if_err = 1'b0;
  assign d_err  = 1'b0;
`endif

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a byte memory model plus a word-level reference
// model (byte array, expected beat list) checked against the DUT.
module tb_mem_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAB      = 12;
  localparam int MEM_SIZE = 4096;

  logic           clk;
  logic           rst_n;
  logic           if_req;
  logic [AW-1:0]  if_addr;
  logic           if_valid;
  logic [DW-1:0]  if_rdata;
  logic           if_err;
  logic           d_req;
  logic           d_we;
  logic [AW-1:0]  d_addr;
  logic [DW-1:0]  d_wdata;
  logic [3:0]     d_be;
  logic           d_valid;
  logic [DW-1:0]  d_rdata;
  logic           d_err;
  logic           mem_en;
  logic           mem_we;
  logic [MAB-1:0] mem_addr;
  logic [7:0]     mem_wdata;
  logic [7:0]     mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [MAB-1:0] addr;
    logic           we;
    logic [7:0]     wdata;
  } beat_t;

  logic [7:0] mem     [0:MEM_SIZE-1];
  logic [7:0] ref_mem [0:MEM_SIZE-1];
  beat_t      beats[$];
  beat_t      exp_beats[$];

  mem_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .MEM_ADDR_BITS (MAB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory with one-cycle read latency; also logs every access beat.
  always @(posedge clk) begin
    if (mem_en) begin
      beats.push_back(beat_t'{addr: mem_addr, we: mem_we, wdata: mem_wdata});
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Word-level reference: expected data, error, latency and beat list.
  task automatic model_txn(input bit is_data, input bit we, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output logic [31:0] exp_rdata, output logic exp_err,
                           output int exp_lat);
    int base;
    int a;
    exp_beats.delete();
    exp_rdata = '0;
    exp_err   = 1'b0;
    exp_lat   = 6;
    base      = int'(addr % MEM_SIZE);
`ifdef MEM_ARB_MISALIGN_CHK_EN
    if (base % 4 != 0) begin
      exp_err = 1'b1;
      exp_lat = 1;
      return;
    end
`endif
    for (int k = 0; k < 4; k++) begin
      a = (base + k) % MEM_SIZE;
      if (is_data && we) begin
        if (be[k]) begin
          ref_mem[a] = wdata[8*k +: 8];
          exp_beats.push_back(beat_t'{addr: MAB'(a), we: 1'b1, wdata: wdata[8*k +: 8]});
        end
      end else begin
        exp_rdata[8*k +: 8] = ref_mem[a];
        exp_beats.push_back(beat_t'{addr: MAB'(a), we: 1'b0, wdata: 8'h00});
      end
    end
  endtask

  // Drive one request, hold it until its valid pulse, return what the DUT reported.
  task automatic applyStimulus(input bit is_data, input bit we, input logic [AW-1:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input bit scramble, output logic [31:0] rdata,
                               output logic err, output int lat, output bit timed_out);
    beats.delete();
    rdata     = '0;
    err       = 1'b0;
    lat       = -1;
    timed_out = 1'b1;
    @(posedge clk);
    #1;
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (is_data ? d_valid : if_valid) begin
        lat       = n;
        timed_out = 1'b0;
        rdata     = is_data ? d_rdata : if_rdata;
        err       = is_data ? d_err : if_err;
        break;
      end
      if (scramble && n == 1) begin
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
        d_we = 1'($urandom); if_addr = $urandom;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if_valid, d_valid, if_err, d_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: observed %b, expected 0000", {if_valid, d_valid, if_err, d_err});
    end
    checks++;
    if ({mem_en, mem_we} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_mem_strobes: observed %b, expected 00", {mem_en, mem_we});
    end
    checks++;
    if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: observed %h/%h, expected 0/0", if_rdata, d_rdata);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_fetch_known;
    logic [31:0] rd; logic er; int lat; bit to;
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
    for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, er, lat, to);
    checks++;
    if (to || lat != 6) begin
      errors++;
      $display("[TB] FAIL fetch0_latency: observed %0d (timeout %0d), expected 6", lat, to);
    end
    checks++;
    if (rd !== 32'h00500013 || er !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch0_rdata: observed %h err %b, expected 00500013 err 0", rd, er);
    end
    checks++;
    if (beats.size() != 4 || beats[0].addr != 0 || beats[1].addr != 1 ||
        beats[2].addr != 2 || beats[3].addr != 3) begin
      errors++;
      $display("[TB] FAIL fetch0_beats: observed %0d beats, expected 4 at 0..3", beats.size());
    end
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0 || if_rdata !== 32'h00500013) begin
      errors++;
      $display("[TB] FAIL fetch0_hold: observed valid %b rdata %h, expected 0 00500013", if_valid, if_rdata);
    end
  endtask

  task automatic test_tie;
    logic [31:0] exp_d, exp_f; logic e; int l;
    bit seen; int n;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, exp_d, e, l);
    model_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, exp_f, e, l);
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (if_valid || d_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || d_valid !== 1'b1 || if_valid !== 1'b0 || d_rdata !== exp_d) begin
      errors++;
      $display("[TB] FAIL tie_first_data: observed d_valid %b if_valid %b rdata %h, expected 1 0 %h",
               d_valid, if_valid, d_rdata, exp_d);
    end
    d_req = 1'b0;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (if_valid) begin seen = 1'b1; n = i; end
    end
    checks++;
    if (!seen || n != 7 || if_rdata !== exp_f) begin
      errors++;
      $display("[TB] FAIL tie_fetch_next: observed gap %0d rdata %h, expected 7 %h", n, if_rdata, exp_f);
    end
    if_req = 1'b0;
  endtask

  task automatic test_store_be;
    logic [31:0] rd, er32; logic er, ee; int lat, el; bit to;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    for (int i = 12'h100; i < 12'h104; i++) ref_mem[i] = mem[i];
    model_txn(1'b1, 1'b1, 32'h100, 32'hAABBCCDD, 4'b0101, er32, ee, el);
    applyStimulus(1'b1, 1'b1, 32'h100, 32'hAABBCCDD, 4'b0101, 1'b0, rd, er, lat, to);
    checks++;
    if (to || lat != 6) begin
      errors++;
      $display("[TB] FAIL store_latency: observed %0d (timeout %0d), expected 6", lat, to);
    end
    checks++;
    if (beats.size() != 2 || beats[0] != beat_t'{addr: 12'h100, we: 1'b1, wdata: 8'hDD} ||
        beats[1] != beat_t'{addr: 12'h102, we: 1'b1, wdata: 8'hBB}) begin
      errors++;
      $display("[TB] FAIL store_beats: observed %0d beats, expected DD@100 BB@102", beats.size());
    end
    checks++;
    if ({mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} !== 32'h44BB22DD) begin
      errors++;
      $display("[TB] FAIL store_mem: observed %h, expected 44bb22dd",
               {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]});
    end
  endtask

  // Checks one transaction against the reference model (used by the edge-address tests).
  task automatic test_model_txn(input string name, input bit is_data, input logic [AW-1:0] addr);
    logic [31:0] rd, exp_rd; logic er, exp_er; int lat, exp_lat; bit to; bit bad;
    model_txn(is_data, 1'b0, addr, 32'h0, 4'h0, exp_rd, exp_er, exp_lat);
    applyStimulus(is_data, 1'b0, addr, 32'h0, 4'h0, 1'b0, rd, er, lat, to);
    checks++;
    if (to || lat != exp_lat || rd !== exp_rd || er !== exp_er) begin
      errors++;
      $display("[TB] FAIL %s_resp: observed lat %0d rdata %h err %b, expected %0d %h %b",
               name, lat, rd, er, exp_lat, exp_rd, exp_er);
    end
    bad = (beats.size() != exp_beats.size());
    for (int i = 0; i < beats.size() && !bad; i++)
      if (beats[i].addr != exp_beats[i].addr || beats[i].we != 1'b0) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL %s_beats: observed %0d beats, expected %0d", name, beats.size(), exp_beats.size());
    end
  endtask

  task automatic test_reset_mid;
    bit bad;
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    repeat (4) @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 12'h202) begin
      errors++;
      $display("[TB] FAIL abort_beat2: observed en %b addr %h, expected 1 202", mem_en, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_mem_en: observed %b, expected 0", mem_en);
    end
    d_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (d_valid || mem_en) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL abort_quiet: observed activity 1, expected 0");
    end
    test_model_txn("after_abort", 1'b1, 32'h200);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d, exp_f; logic e; int l;
    int got; bit want_data;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_txn(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, exp_d, e, l);
    model_txn(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, exp_f, e, l);
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    got = 0;
    for (int n = 0; n < 60 && got < 4; n++) begin
      @(negedge clk);
      if (if_valid || d_valid) begin
        want_data = (got % 2 == 0);
        checks++;
        if (n != 6 + 7 * got || d_valid !== want_data || if_valid !== !want_data ||
            (want_data ? d_rdata : if_rdata) !== (want_data ? exp_d : exp_f)) begin
          errors++;
          $display("[TB] FAIL b2b_%0d: observed cycle %0d d %b f %b, expected cycle %0d d %b",
                   got, n, d_valid, if_valid, 6 + 7 * got, want_data);
        end
        got++;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("[TB] FAIL b2b_count: observed %0d completions, expected 4", got);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, exp_rd, wd; logic er, exp_er; int lat, exp_lat; bit to, bad;
    bit is_data, we; logic [AW-1:0] a; logic [3:0] be;
    for (int i = 0; i < 40; i++) begin
      is_data = 1'($urandom);
      we      = is_data & 1'($urandom);
      a       = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wd      = $urandom;
      be      = 4'($urandom);
      model_txn(is_data, we, a, wd, be, exp_rd, exp_er, exp_lat);
      applyStimulus(is_data, we, a, wd, be, 1'b1, rd, er, lat, to);
      checks++;
      if (to || lat != exp_lat || er !== exp_er) begin
        errors++;
        $display("[TB] FAIL rand%0d_resp: observed lat %0d err %b, expected %0d %b", i, lat, er, exp_lat, exp_er);
      end
      if (!(is_data && we)) begin
        checks++;
        if (rd !== exp_rd) begin
          errors++;
          $display("[TB] FAIL rand%0d_rdata: observed %h, expected %h", i, rd, exp_rd);
        end
      end
      bad = (beats.size() != exp_beats.size());
      for (int k = 0; k < beats.size() && !bad; k++)
        if (beats[k].addr != exp_beats[k].addr || beats[k].we != exp_beats[k].we ||
            (exp_beats[k].we && beats[k].wdata != exp_beats[k].wdata)) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("[TB] FAIL rand%0d_beats: observed %0d beats, expected %0d", i, beats.size(), exp_beats.size());
      end
    end
  endtask

  initial begin
    int diffs;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = 4'h0; mem_rdata = 8'h00;
    for (int i = 0; i < MEM_SIZE; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset;
    test_fetch_known;
    test_tie;
    test_store_be;
    test_model_txn("wrap_ffe", 1'b1, 32'hFFE);
    test_model_txn("fetch_002", 1'b0, 32'h002);
    test_reset_mid;
    test_back_to_back;
    test_random;
    diffs = 0;
    for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) diffs++;
    checks++;
    if (diffs != 0) begin
      errors++;
      $display("[TB] FAIL memory_image: observed %0d differing bytes, expected 0", diffs);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
